// File: rtl/uart_receiver.sv
// UART receive path: synchronizes the serial line, qualifies the start bit, samples
// data LSB first at mid-bit, checks optional parity and the stop bit, then reports the word.
module uart_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_en_i,
    input  logic                  rx_i,
    input  logic                  tick_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  rx_busy_o
);

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_WIDTH);
    localparam logic [TCNT_W-1:0] T_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] T_END  = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic                  rx_m, rx_s, rx_d;
    logic [TCNT_W-1:0]     tcnt;
    logic [BCNT_W-1:0]     bcnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  acc_q;
    logic                  par_en_q, par_odd_q;
    logic                  pend_perr_q;
    logic                  fall_edge, tick_mid, tick_end;
    logic                  sample_data, deliver;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall_edge = rx_d & ~rx_s;
    assign tick_mid  = tick_i && (tcnt == T_MID);
    assign tick_end  = tick_i && (tcnt == T_END);
    assign rx_busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sample_data = 1'b0;
        deliver     = 1'b0;
        if (!rx_en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   if (fall_edge) state_nxt = START;
                START:  if (tick_mid) state_nxt = rx_s ? IDLE : DATA;
                DATA: begin
                    if (tick_end) begin
                        sample_data = 1'b1;
                        if (bcnt == B_LAST) state_nxt = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: if (tick_end) state_nxt = STOP;
                STOP: begin
                    if (tick_end) begin
                        deliver   = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters, latched frame config, parity tracking and the result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt         <= '0;
            bcnt         <= '0;
            acc_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            pend_perr_q  <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_valid_o <= deliver;
            if (!rx_en_i || state == IDLE || state == DONE) begin
                tcnt        <= '0;
                bcnt        <= '0;
                acc_q       <= 1'b0;
                pend_perr_q <= 1'b0;
                if (rx_en_i && state == IDLE && fall_edge) begin
                    par_en_q  <= parity_en_i;
                    par_odd_q <= parity_odd_i;
                end
            end else if (tick_i) begin
                if (state == START) tcnt <= tick_mid ? '0 : tcnt + 1'b1;
                else                tcnt <= tick_end ? '0 : tcnt + 1'b1;
                if (sample_data) begin
                    bcnt  <= bcnt + 1'b1;
                    acc_q <= acc_q ^ rx_s;
                end
                if (state == PARITY && tick_end)
                    pend_perr_q <= (rx_s != (acc_q ^ par_odd_q));
            end
            if (deliver) begin
                rx_data_o    <= shift_q;
                parity_err_o <= pend_perr_q;
                frame_err_o  <= ~rx_s;
            end
        end
    end

    // Data shift register: bits enter at the MSB so the first bit ends at the LSB
    always_ff @(posedge clk) begin
        if (!rx_en_i || state == IDLE)
            shift_q <= '0;
        else if (sample_data)
            shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: randomized and directed frames are driven
// on rx_i and the reported words/flags are compared with a frame-level reference model.
module tb_uart_receiver;

    localparam int DW       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = OS * TICK_DIV;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_en_i;
    logic          rx_i;
    logic          tick_i;
    logic          parity_en_i;
    logic          parity_odd_i;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          parity_err_o;
    logic          frame_err_o;
    logic          rx_busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] cap_data[$];
    bit         cap_perr[$];
    bit         cap_ferr[$];
    logic [7:0] exp_data[$];
    bit         exp_perr[$];
    bit         exp_ferr[$];
    logic [7:0] last_sent;

    uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_en_i      (rx_en_i),
        .rx_i         (rx_i),
        .tick_i       (tick_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .rx_busy_o    (rx_busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        tick_i = 1'b0;
        forever begin
            for (int k = 0; k < TICK_DIV; k++) begin
                @(negedge clk);
                tick_i = (k == TICK_DIV - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && rx_valid_o === 1'b1) begin
            cap_data.push_back(rx_data_o);
            cap_perr.push_back(parity_err_o);
            cap_ferr.push_back(frame_err_o);
        end
    end

    task automatic clear_queues();
        cap_data.delete(); cap_perr.delete(); cap_ferr.delete();
        exp_data.delete(); exp_perr.delete(); exp_ferr.delete();
    endtask

    task automatic drive_bit(input bit b);
        rx_i = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    // Reference model: a frame yields its data, a parity error when the received parity
    // bit disagrees with the chosen parity of the data, and a frame error when stop is low.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                              input bit pbit, input bit stopb);
        parity_en_i  = pen;
        parity_odd_i = podd;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
        exp_data.push_back(d);
        exp_perr.push_back(pen && (pbit != ((^d) ^ podd)));
        exp_ferr.push_back(!stopb);
        last_sent = d;
    endtask

    task automatic test_reset();
        rx_i = 1'b1; rx_en_i = 1'b1; parity_en_i = 1'b0; parity_odd_i = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o} !== 13'h0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o});
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if ({rx_valid_o, rx_busy_o} !== 2'b00)
            $display("FAIL reset_idle: got valid/busy %b expected 00", {rx_valid_o, rx_busy_o});
        else pass_cnt++;
    endtask

    task automatic test_8n1();
        clear_queues();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        for (int n = 0; n < 3; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1);
            idle_bits($urandom_range(0, 1));
        end
        idle_bits(1);
        total_cnt++;
        if (cap_data.size() !== exp_data.size())
            $display("FAIL 8n1_count: got %0d expected %0d", cap_data.size(), exp_data.size());
        else pass_cnt++;
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            total_cnt++;
            if ({cap_data[i], cap_perr[i], cap_ferr[i]} !== {exp_data[i], exp_perr[i], exp_ferr[i]})
                $display("FAIL 8n1_frame%0d: got %h/%b/%b expected %h/%b/%b", i,
                         cap_data[i], cap_perr[i], cap_ferr[i], exp_data[i], exp_perr[i], exp_ferr[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rx_busy_o !== 1'b0) $display("FAIL 8n1_busy_after: got %b expected 0", rx_busy_o);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        bit pen, podd, pbit;
        clear_queues();
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        total_cnt++;
        if (parity_err_o !== 1'b1) $display("FAIL parity_even_bad: got %b expected 1", parity_err_o);
        else pass_cnt++;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        for (int n = 0; n < 5; n++) begin
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            send_frame(8'($urandom_range(0, 255)), pen, podd, pbit, 1'b1);
            idle_bits(1);
        end
        total_cnt++;
        if (cap_data.size() !== exp_data.size())
            $display("FAIL parity_count: got %0d expected %0d", cap_data.size(), exp_data.size());
        else pass_cnt++;
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            total_cnt++;
            if ({cap_data[i], cap_perr[i], cap_ferr[i]} !== {exp_data[i], exp_perr[i], exp_ferr[i]})
                $display("FAIL parity_frame%0d: got %h/%b/%b expected %h/%b/%b", i,
                         cap_data[i], cap_perr[i], cap_ferr[i], exp_data[i], exp_perr[i], exp_ferr[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_frame_err();
        bit busy_seen = 1'b0;
        clear_queues();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        for (int c = 0; c < 3 * BIT_CLK; c++) begin
            @(negedge clk);
            if (rx_busy_o !== 1'b0) busy_seen = 1'b1;
        end
        total_cnt++;
        if (busy_seen !== 1'b0) $display("FAIL break_no_restart: got busy %b expected 0", busy_seen);
        else pass_cnt++;
        total_cnt++;
        if ({rx_data_o, frame_err_o, parity_err_o} !== {8'h5A, 1'b1, 1'b0})
            $display("FAIL frame_err_flags: got %h/%b/%b expected 5a/1/0",
                     rx_data_o, frame_err_o, parity_err_o);
        else pass_cnt++;
        idle_bits(1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        total_cnt++;
        if (cap_data.size() !== exp_data.size())
            $display("FAIL frame_count: got %0d expected %0d", cap_data.size(), exp_data.size());
        else pass_cnt++;
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            total_cnt++;
            if ({cap_data[i], cap_perr[i], cap_ferr[i]} !== {exp_data[i], exp_perr[i], exp_ferr[i]})
                $display("FAIL frame_frame%0d: got %h/%b/%b expected %h/%b/%b", i,
                         cap_data[i], cap_perr[i], cap_ferr[i], exp_data[i], exp_perr[i], exp_ferr[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        parity_en_i = 1'b0;
        rx_i = 1'b0;
        repeat ((OS / 2 - 2) * TICK_DIV) @(negedge clk);
        idle_bits(2);
        total_cnt++;
        if (cap_data.size() !== 0 || rx_data_o !== last_sent || rx_busy_o !== 1'b0)
            $display("FAIL glitch_reject: got %0d valids data %h busy %b expected 0 valids data %h busy 0",
                     cap_data.size(), rx_data_o, rx_busy_o, last_sent);
        else pass_cnt++;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        total_cnt++;
        if (cap_data.size() !== 1 || {cap_data[0], cap_perr[0], cap_ferr[0]} !== {exp_data[0], exp_perr[0], exp_ferr[0]})
            $display("FAIL glitch_followup: got %0d valids data %h expected 1 valid data %h",
                     cap_data.size(), cap_data[0], exp_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        logic [7:0] partial;
        clear_queues();
        partial = 8'hC6;
        parity_en_i = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(partial[i]);
        rx_en_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (rx_busy_o !== 1'b0) $display("FAIL disable_idle: got busy %b expected 0", rx_busy_o);
        else pass_cnt++;
        idle_bits(2);
        total_cnt++;
        if (cap_data.size() !== 0 || rx_data_o !== last_sent)
            $display("FAIL disable_no_valid: got %0d valids data %h expected 0 valids data %h",
                     cap_data.size(), rx_data_o, last_sent);
        else pass_cnt++;
        rx_en_i = 1'b1;
        idle_bits(1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        total_cnt++;
        if (cap_data.size() !== 1 || {cap_data[0], cap_perr[0], cap_ferr[0]} !== {exp_data[0], exp_perr[0], exp_ferr[0]})
            $display("FAIL reenable_frame: got %0d valids data %h expected 1 valid data %h",
                     cap_data.size(), cap_data[0], exp_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] third;
        clear_queues();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++)
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1);
        idle_bits(1);
        total_cnt++;
        if (cap_data.size() !== exp_data.size())
            $display("FAIL b2b_count: got %0d expected %0d", cap_data.size(), exp_data.size());
        else pass_cnt++;
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            total_cnt++;
            if ({cap_data[i], cap_perr[i], cap_ferr[i]} !== {exp_data[i], exp_perr[i], exp_ferr[i]})
                $display("FAIL b2b_frame%0d: got %h/%b/%b expected %h/%b/%b", i,
                         cap_data[i], cap_perr[i], cap_ferr[i], exp_data[i], exp_perr[i], exp_ferr[i]);
            else pass_cnt++;
        end
        // Reset in the middle of a frame
        clear_queues();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        clear_queues();
        third = 8'h77;
        parity_en_i = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(third[i]);
        reset_n = 1'b0;
        rx_i = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o} !== 13'h0)
            $display("FAIL midframe_reset: got %h expected 0",
                     {rx_data_o, rx_valid_o, parity_err_o, frame_err_o, rx_busy_o});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle_bits(2);
        total_cnt++;
        if (cap_data.size() !== 0 || rx_busy_o !== 1'b0)
            $display("FAIL midframe_no_valid: got %0d valids busy %b expected 0 valids busy 0",
                     cap_data.size(), rx_busy_o);
        else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b0; rx_en_i = 1'b0; rx_i = 1'b1;
        parity_en_i = 1'b0; parity_odd_i = 1'b0;
        last_sent = 8'h00;
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_enable();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
